// File: rtl/mips_trace_buffer.sv
// Trace buffer that records (PC, ALU result) pairs from a MIPS core into a FIFO.
// Recording stops for good once the PC holds still for HALT_CYCLES cycles.
module mips_trace_buffer #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned HALT_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              pc_in,
  input  logic [31:0]              result_in,
  input  logic                     capture_en,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [31:0]              rd_pc,
  output logic [31:0]              rd_result,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     halted
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(HALT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
  } entry_t;

  logic          r_rst_sync;
  logic          w_rst_n;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [SW-1:0] r_stall;
  logic [SW-1:0] w_stall_nxt;
  logic [31:0]   r_last_pc;
  logic [31:0]   w_last_pc_nxt;
  logic          w_cap;
  logic          w_pop;
  logic          w_wr;
  logic          w_drop;
  logic [CW-1:0] w_count_nxt;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_overflow;
  logic          r_halted;
  logic          r_rd_valid;
  logic [31:0]   r_rd_pc;
  logic [31:0]   r_rd_result;
  entry_t        r_mem [DEPTH];
  entry_t        w_rd_entry;

  // Assert asynchronously, release on the first clock after reset rises.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rst_sync <= 1'b0;
    else        r_rst_sync <= 1'b1;
  end
  assign w_rst_n = r_rst_sync;

  // Capture qualification and halt detection.
  always_comb begin
    w_state_nxt   = r_state;
    w_stall_nxt   = r_stall;
    w_last_pc_nxt = r_last_pc;
    w_cap         = 1'b0;
    case (r_state)
      IDLE: begin
        if (capture_en) begin
          w_state_nxt   = RUN;
          w_cap         = 1'b1;
          w_last_pc_nxt = pc_in;
        end
      end
      RUN: begin
        w_last_pc_nxt = pc_in;
        if (pc_in == r_last_pc) begin
          if (r_stall != SW'(HALT_CYCLES)) w_stall_nxt = r_stall + SW'(1);
        end else begin
          w_stall_nxt = '0;
          w_cap       = capture_en;
        end
        if (w_stall_nxt == SW'(HALT_CYCLES)) w_state_nxt = HALT;
      end
      default: begin
      end
    endcase
  end

  // A full FIFO still accepts a capture when a pop frees a slot in the same cycle.
  always_comb begin
    w_pop       = rd_en & ~r_empty;
    w_wr        = w_cap & (~r_full | w_pop);
    w_drop      = w_cap & r_full & ~w_pop;
    w_count_nxt = r_count + CW'(w_wr) - CW'(w_pop);
  end

  assign w_rd_entry = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= IDLE;
      r_stall     <= '0;
      r_last_pc   <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_overflow  <= 1'b0;
      r_halted    <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_pc     <= '0;
      r_rd_result <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_stall    <= w_stall_nxt;
      r_last_pc  <= w_last_pc_nxt;
      r_halted   <= (w_state_nxt == HALT);
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == CW'(DEPTH));
      r_empty    <= (w_count_nxt == '0);
      r_rd_valid <= w_pop;
      if (w_drop) r_overflow <= 1'b1;
      if (w_wr)   r_wr_ptr   <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + AW'(1);
        r_rd_pc     <= w_rd_entry.pc;
        r_rd_result <= w_rd_entry.result;
      end
    end
  end

  // Storage is not reset; pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= '{pc: pc_in, result: result_in};
  end

  assign rd_valid  = r_rd_valid;
  assign rd_pc     = r_rd_pc;
  assign rd_result = r_rd_result;
  assign count     = r_count;
  assign full      = r_full;
  assign empty     = r_empty;
  assign overflow  = r_overflow;
  assign halted    = r_halted;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Self-checking bench for mips_trace_buffer: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_mips_trace_buffer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned HALT  = 4;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in;
  logic [31:0] result_in;
  logic        capture_en;
  logic        rd_en;
  logic        rd_valid;
  logic [31:0] rd_pc;
  logic [31:0] rd_result;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        halted;

  mips_trace_buffer #(.DEPTH(DEPTH), .HALT_CYCLES(HALT)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_in      (pc_in),
    .result_in  (result_in),
    .capture_en (capture_en),
    .rd_en      (rd_en),
    .rd_valid   (rd_valid),
    .rd_pc      (rd_pc),
    .rd_result  (rd_result),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: FIFO contents as a queue plus trace-session status.
  logic [63:0] q[$];
  bit          m_started;
  bit          m_halted;
  logic [31:0] m_last;
  int          m_stall;
  bit          m_ovf;
  bit          m_rv;
  logic [31:0] m_rpc;
  logic [31:0] m_rres;

  task automatic model_reset();
    q.delete();
    m_started = 0;
    m_halted  = 0;
    m_last    = '0;
    m_stall   = 0;
    m_ovf     = 0;
    m_rv      = 0;
    m_rpc     = '0;
    m_rres    = '0;
  endtask

  task automatic model_clock(input logic ce, input logic [31:0] pc,
                             input logic [31:0] res, input logic rd);
    logic [63:0] e;
    bit cap;
    m_rv = rd && (q.size() > 0);
    if (m_rv) begin
      e      = q.pop_front();
      m_rpc  = e[63:32];
      m_rres = e[31:0];
    end
    cap = 0;
    if (!m_started) begin
      if (ce) begin
        cap       = 1;
        m_started = 1;
        m_last    = pc;
      end
    end else if (!m_halted) begin
      if (pc == m_last) begin
        if (m_stall < HALT) m_stall++;
        if (m_stall == HALT) m_halted = 1;
      end else begin
        m_stall = 0;
        cap     = ce;
      end
      m_last = pc;
    end
    if (cap) begin
      if (q.size() < DEPTH) q.push_back({pc, res});
      else                  m_ovf = 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    check({where, ".rd_valid"},  32'(rd_valid),  32'(m_rv));
    check({where, ".rd_pc"},     rd_pc,          m_rpc);
    check({where, ".rd_result"}, rd_result,      m_rres);
    check({where, ".count"},     32'(count),     32'(q.size()));
    check({where, ".full"},      32'(full),      32'(q.size() == DEPTH));
    check({where, ".empty"},     32'(empty),     32'(q.size() == 0));
    check({where, ".overflow"},  32'(overflow),  32'(m_ovf));
    check({where, ".halted"},    32'(halted),    32'(m_halted));
  endtask

  task automatic step(input string where, input logic ce, input logic [31:0] pc,
                      input logic [31:0] res, input logic rd);
    @(negedge clk);
    capture_en = ce;
    pc_in      = pc;
    result_in  = res;
    rd_en      = rd;
    @(posedge clk);
    model_clock(ce, pc, res, rd);
    #1;
    check_all(where);
  endtask

  // Drops reset mid-cycle, checks outputs before any clock, then releases.
  task automatic pulse_reset(input bit hold_edges);
    @(negedge clk);
    capture_en = 1'b0;
    rd_en      = 1'b0;
    reset      = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    if (hold_edges) begin
      repeat (2) @(posedge clk);
      #2;
    end else begin
      #1;
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step("post_reset", 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] cur_pc;
    reset      = 1'b1;
    capture_en = 1'b0;
    rd_en      = 1'b0;
    pc_in      = '0;
    result_in  = '0;
    #2 reset   = 1'b0;
    pulse_reset(1'b1);

    // Pop request on an empty FIFO is ignored.
    step("rd_empty", 1'b0, 32'h0, 32'h0, 1'b1);

    // Four captures then four pops in order.
    for (int i = 0; i < 4; i++) step("cap4", 1'b1, 32'(4 * i), 32'(10 * (i + 1)), 1'b0);
    for (int i = 0; i < 4; i++) step("pop4", 1'b0, 32'(100 + 4 * i), 32'h0, 1'b1);

    // Overfill: 20 captures into 16 slots, then drain.
    for (int i = 0; i < 20; i++) step("fill20", 1'b1, 32'h1000 + 32'(4 * i), 32'hA000 + 32'(i), 1'b0);
    for (int i = 0; i < 16; i++) step("drain16", 1'b0, 32'h2000 + 32'(4 * i), 32'h0, 1'b1);

    // Capture and pop together while full.
    for (int i = 0; i < 16; i++) step("refill", 1'b1, 32'h3000 + 32'(4 * i), 32'hB000 + 32'(i), 1'b0);
    step("full_cap_pop", 1'b1, 32'h4000, 32'h0000ABCD, 1'b1);
    for (int i = 0; i < 16; i++) step("drain_b", 1'b0, 32'h5000 + 32'(4 * i), 32'h0, 1'b1);

    // Random traffic, three rounds with increasing read pressure.
    for (int r = 0; r < 3; r++) begin
      pulse_reset(1'b0);
      cur_pc = $urandom & 32'h0000FFFC;
      for (int i = 0; i < 120; i++) begin
        if ($urandom_range(0, 9) < 7) cur_pc = cur_pc + 32'd4;
        step("random", ($urandom_range(0, 4) != 0), cur_pc, $urandom, ($urandom_range(0, 3) <= r));
      end
    end

    // Halt on a held PC, no capture afterwards, reads still served.
    pulse_reset(1'b0);
    for (int i = 0; i < 5; i++) step("pre_halt", 1'b1, 32'h8 + 32'(4 * i), 32'hC000 + 32'(i), 1'b0);
    step("cap_20", 1'b1, 32'h20, 32'h0000C020, 1'b0);
    for (int i = 0; i < 4; i++) step("hold_20", 1'b1, 32'h20, 32'h0000C020, 1'b0);
    step("after_halt", 1'b1, 32'h24, 32'h0000C024, 1'b0);
    step("pop_in_halt", 1'b0, 32'h24, 32'h0, 1'b1);

    // Reset pulse between edges clears everything; the next capture is read back first.
    pulse_reset(1'b0);
    step("cap_after_rst", 1'b1, 32'h100, 32'h55, 1'b0);
    step("pop_after_rst", 1'b0, 32'h104, 32'h0, 1'b1);
    step("rd_empty_end", 1'b0, 32'h108, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
